// File: rtl/ram32x4_arbiter_if.sv
// Bus bundle between the RAM arbiter and its surroundings: two single-word
// requesters (A, B), the bulk-clear request, and the single-port RAM itself.
// The slave modport is the arbiter's view. The master modport is the
// environment's view: requesters, clear source and the RAM.
interface ram32x4_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 4
);
  // Requester A
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_done;
  logic [DATA_W-1:0] a_rdata;

  // Requester B
  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_done;
  logic [DATA_W-1:0] b_rdata;

  // Bulk clear
  logic              clr_req;
  logic              clr_busy;
  logic              clr_done;

  // RAM side
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_q;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_done, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_done, b_rdata,
    input  clr_req,
    output clr_busy, clr_done,
    output ram_address, ram_data, ram_wren,
    input  ram_q
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_done, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_done, b_rdata,
    output clr_req,
    input  clr_busy, clr_done,
    input  ram_address, ram_data, ram_wren,
    output ram_q
  );
endinterface

// File: rtl/ram32x4_arbiter.sv
// Shares one single-port synchronous RAM between requesters A and B and a
// bulk-clear engine. A and B each get one word per transaction through a
// level req / pulsed done handshake. Ties go to whichever requester was not
// served last. A clear walks every address writing zero and always beats A/B.
// All outputs come straight from registers.
module ram32x4_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 4,
  parameter int DEPTH  = 32
) (
  input logic              clock,
  input logic              resetn,
  ram32x4_arbiter_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCESS = 3'd1;
  localparam logic [2:0] S_RESP   = 3'd2;
  localparam logic [2:0] S_CLEAR  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [1:0] OWN_A   = 2'd0;
  localparam logic [1:0] OWN_B   = 2'd1;
  localparam logic [1:0] OWN_CLR = 2'd2;

  localparam logic LAST_A = 1'b0;
  localparam logic LAST_B = 1'b1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [2:0]        state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] ram_address_q, ram_address_d;
  logic [DATA_W-1:0] ram_data_q, ram_data_d;
  logic              ram_wren_q, ram_wren_d;
  logic              a_done_q, a_done_d;
  logic              b_done_q, b_done_d;
  logic              clr_done_q, clr_done_d;
  logic              clr_busy_q, clr_busy_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

  // B wins when it is the only requester, or on a tie when A was served last
  logic grant_b;
  assign grant_b = bus.b_req && (!bus.a_req || (last_q == LAST_A));

  // Next-state and next-output logic. Pulses and write enable default low,
  // everything else holds.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_d        = last_q;
    we_d          = we_q;
    cnt_d         = cnt_q;
    ram_address_d = ram_address_q;
    ram_data_d    = ram_data_q;
    ram_wren_d    = 1'b0;
    a_done_d      = 1'b0;
    b_done_d      = 1'b0;
    clr_done_d    = 1'b0;
    clr_busy_d    = 1'b0;
    a_rdata_d     = a_rdata_q;
    b_rdata_d     = b_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (bus.clr_req) begin
          state_d       = S_CLEAR;
          owner_d       = OWN_CLR;
          cnt_d         = '0;
          ram_address_d = '0;
          ram_data_d    = '0;
          ram_wren_d    = 1'b1;
          clr_busy_d    = 1'b1;
        end else if (bus.a_req || bus.b_req) begin
          state_d       = S_ACCESS;
          owner_d       = grant_b ? OWN_B : OWN_A;
          last_d        = grant_b ? LAST_B : LAST_A;
          we_d          = grant_b ? bus.b_we : bus.a_we;
          ram_address_d = grant_b ? bus.b_addr : bus.a_addr;
          ram_data_d    = grant_b ? bus.b_wdata : bus.a_wdata;
          ram_wren_d    = grant_b ? bus.b_we : bus.a_we;
        end
      end
      S_ACCESS: begin
        // RAM has sampled address/data at the edge ending this cycle
        state_d = S_RESP;
      end
      S_RESP: begin
        // ram_q now reflects the address registered one edge ago
        if (!we_q) begin
          if (owner_q == OWN_A) a_rdata_d = bus.ram_q;
          else                  b_rdata_d = bus.ram_q;
        end
        a_done_d = (owner_q == OWN_A);
        b_done_d = (owner_q == OWN_B);
        state_d  = S_DONE;
      end
      S_CLEAR: begin
        if (cnt_q == LAST_ADDR) begin
          // Counter parks on the last address rather than wrapping
          state_d    = S_DONE;
          clr_done_d = 1'b1;
        end else begin
          cnt_d         = cnt_q + ADDR_W'(1);
          ram_address_d = cnt_q + ADDR_W'(1);
          ram_data_d    = '0;
          ram_wren_d    = 1'b1;
          clr_busy_d    = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset kills any in-flight write at once
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      owner_q       <= OWN_A;
      last_q        <= LAST_B;
      we_q          <= 1'b0;
      cnt_q         <= '0;
      ram_address_q <= '0;
      ram_data_q    <= '0;
      ram_wren_q    <= 1'b0;
      a_done_q      <= 1'b0;
      b_done_q      <= 1'b0;
      clr_done_q    <= 1'b0;
      clr_busy_q    <= 1'b0;
      a_rdata_q     <= '0;
      b_rdata_q     <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_q        <= last_d;
      we_q          <= we_d;
      cnt_q         <= cnt_d;
      ram_address_q <= ram_address_d;
      ram_data_q    <= ram_data_d;
      ram_wren_q    <= ram_wren_d;
      a_done_q      <= a_done_d;
      b_done_q      <= b_done_d;
      clr_done_q    <= clr_done_d;
      clr_busy_q    <= clr_busy_d;
      a_rdata_q     <= a_rdata_d;
      b_rdata_q     <= b_rdata_d;
    end
  end

  assign bus.ram_address = ram_address_q;
  assign bus.ram_data    = ram_data_q;
  assign bus.ram_wren    = ram_wren_q;
  assign bus.a_done      = a_done_q;
  assign bus.b_done      = b_done_q;
  assign bus.clr_done    = clr_done_q;
  assign bus.clr_busy    = clr_busy_q;
  assign bus.a_rdata     = a_rdata_q;
  assign bus.b_rdata     = b_rdata_q;

endmodule

// File: tb/tb_ram32x4_arbiter.sv
// Scoreboard bench for ram32x4_arbiter. Each issued transaction pushes its
// expected completion (owner, cycle of the done pulse, rdata) into a queue.
// A monitor pops and compares on every done pulse. A behavioural 32x4 RAM
// model sits on the RAM port.
module tb_ram32x4_arbiter;

  logic clock;
  logic resetn;
  int   cyc;
  int   checks;
  int   errors;

  ram32x4_arbiter_if #(.ADDR_W(5), .DATA_W(4)) ifc ();

  ram32x4_arbiter #(.ADDR_W(5), .DATA_W(4), .DEPTH(32)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (ifc.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // RAM model: registered read, write on wren; read returns pre-write data
  logic [3:0] mem [32];
  always @(posedge clock) begin
    ifc.ram_q <= mem[ifc.ram_address];
    if (ifc.ram_wren) mem[ifc.ram_address] = ifc.ram_data;
  end

  typedef struct {
    int         who;   // 0=A 1=B 2=clear
    int         cyc;
    logic [3:0] rdata;
  } exp_t;
  exp_t sb[$];

  logic [3:0] exp_a;
  logic [3:0] exp_b;
  int         wren_cnt;
  int         clr_exp_addr;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_done(input int who, input logic [3:0] rdata);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done: owner %0d pulsed with nothing expected (cycle %0d)", who, cyc);
    end else begin
      e = sb.pop_front();
      chk("done_owner", who, e.who);
      chk("done_cycle", cyc, e.cyc);
      if (who != 2) chk("rdata", int'(rdata), int'(e.rdata));
      $display("txn owner=%0d cycle=%0d rdata=%h", who, cyc, rdata);
    end
  endtask

  // Done-pulse monitor
  always @(negedge clock) begin
    if (resetn) begin
      if (ifc.a_done)   check_done(0, ifc.a_rdata);
      if (ifc.b_done)   check_done(1, ifc.b_rdata);
      if (ifc.clr_done) check_done(2, 4'h0);
    end
  end

  // Clear-sweep monitor and write-enable counter
  always @(negedge clock) begin
    if (ifc.ram_wren) wren_cnt++;
    if (resetn && ifc.clr_busy) begin
      chk("clr_addr", int'(ifc.ram_address), clr_exp_addr);
      chk("clr_data", int'(ifc.ram_data), 0);
      chk("clr_wren", int'(ifc.ram_wren), 1);
      clr_exp_addr++;
    end
  end

  task automatic sync();
    @(posedge clock);
    #1;
  endtask

  task automatic a_txn(input logic we, input logic [4:0] addr, input logic [3:0] wd, input int n);
    bit seen;
    ifc.a_we = we; ifc.a_addr = addr; ifc.a_wdata = wd; ifc.a_req = 1'b1;
    for (int k = 0; k < n; k++) begin
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clock);
        if (ifc.a_done) begin seen = 1'b1; break; end
      end
      if (!seen) begin
        checks++; errors++;
        $display("FAIL a_timeout: no a_done within 200 cycles, expected pulse");
      end
    end
    @(posedge clock); #1;
    ifc.a_req = 1'b0;
  endtask

  task automatic b_txn(input logic we, input logic [4:0] addr, input logic [3:0] wd, input int n);
    bit seen;
    ifc.b_we = we; ifc.b_addr = addr; ifc.b_wdata = wd; ifc.b_req = 1'b1;
    for (int k = 0; k < n; k++) begin
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clock);
        if (ifc.b_done) begin seen = 1'b1; break; end
      end
      if (!seen) begin
        checks++; errors++;
        $display("FAIL b_timeout: no b_done within 200 cycles, expected pulse");
      end
    end
    @(posedge clock); #1;
    ifc.b_req = 1'b0;
  endtask

  task automatic push(input int who, input int c, input logic [3:0] rd);
    exp_t e;
    e.who = who; e.cyc = c; e.rdata = rd;
    sb.push_back(e);
  endtask

  task automatic a_read(input logic [4:0] addr, input logic [3:0] expv);
    sync();
    exp_a = expv;
    push(0, cyc + 3, exp_a);
    a_txn(1'b0, addr, 4'h0, 1);
  endtask

  task automatic a_write(input logic [4:0] addr, input logic [3:0] d);
    sync();
    push(0, cyc + 3, exp_a);
    a_txn(1'b1, addr, d, 1);
  endtask

  task automatic b_read(input logic [4:0] addr, input logic [3:0] expv);
    sync();
    exp_b = expv;
    push(1, cyc + 3, exp_b);
    b_txn(1'b0, addr, 4'h0, 1);
  endtask

  task automatic check_outputs_zero();
    chk("rst_ram_wren", int'(ifc.ram_wren), 0);
    chk("rst_ram_address", int'(ifc.ram_address), 0);
    chk("rst_ram_data", int'(ifc.ram_data), 0);
    chk("rst_a_done", int'(ifc.a_done), 0);
    chk("rst_b_done", int'(ifc.b_done), 0);
    chk("rst_clr_done", int'(ifc.clr_done), 0);
    chk("rst_clr_busy", int'(ifc.clr_busy), 0);
    chk("rst_a_rdata", int'(ifc.a_rdata), 0);
    chk("rst_b_rdata", int'(ifc.b_rdata), 0);
  endtask

  task automatic do_reset();
    sync();
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    check_outputs_zero();
    sync();
    resetn = 1'b1;
    exp_a = 4'h0;
    exp_b = 4'h0;
  endtask

  // Watchdog: the run must always terminate
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int t0;
    bit found;
    cyc = 0; checks = 0; errors = 0; wren_cnt = 0; clr_exp_addr = 0;
    exp_a = 4'h0; exp_b = 4'h0;
    for (int i = 0; i < 32; i++) mem[i] = 4'h0;
    ifc.a_req = 1'b0; ifc.a_we = 1'b0; ifc.a_addr = '0; ifc.a_wdata = '0;
    ifc.b_req = 1'b0; ifc.b_we = 1'b0; ifc.b_addr = '0; ifc.b_wdata = '0;
    ifc.clr_req = 1'b0;
    resetn = 1'b0;

    // Reset state
    repeat (3) @(negedge clock);
    check_outputs_zero();
    sync();
    resetn = 1'b1;

    // A writes 0xA to addr 3, then reads it back; one write-enable cycle
    w0 = wren_cnt;
    a_write(5'd3, 4'hA);
    chk("write_wren_cycles", wren_cnt - w0, 1);
    w0 = wren_cnt;
    a_read(5'd3, 4'hA);
    chk("read_wren_cycles", wren_cnt - w0, 0);

    // Both requesters hold req: grants alternate A, B, A, B every 4 cycles
    do_reset();
    mem[5] = 4'h5;
    mem[7] = 4'h7;
    sync();
    t0 = cyc;
    exp_a = 4'h5; exp_b = 4'h7;
    push(0, t0 + 3, 4'h5);
    push(1, t0 + 7, 4'h7);
    push(0, t0 + 11, 4'h5);
    push(1, t0 + 15, 4'h7);
    fork
      a_txn(1'b0, 5'd5, 4'h0, 2);
      b_txn(1'b0, 5'd7, 4'h0, 2);
    join

    // Bulk clear over a memory full of 0xF
    for (int i = 0; i < 32; i++) mem[i] = 4'hF;
    sync();
    t0 = cyc;
    clr_exp_addr = 0;
    w0 = wren_cnt;
    push(2, t0 + 33, 4'h0);
    ifc.clr_req = 1'b1;
    sync();
    ifc.clr_req = 1'b0;
    repeat (40) @(negedge clock);
    chk("clr_busy_cycles", clr_exp_addr, 32);
    chk("clr_wren_cycles", wren_cnt - w0, 32);
    a_read(5'd0, 4'h0);
    a_read(5'd17, 4'h0);
    a_read(5'd31, 4'h0);

    // Clear and A write rise together: clear first, then A
    mem[4] = 4'h3;
    sync();
    t0 = cyc;
    clr_exp_addr = 0;
    push(2, t0 + 33, 4'h0);
    push(0, t0 + 37, exp_a);
    ifc.clr_req = 1'b1;
    fork
      a_txn(1'b1, 5'd4, 4'h9, 1);
      begin sync(); ifc.clr_req = 1'b0; end
    join
    a_read(5'd4, 4'h9);

    // Reset in the clear cycle addressing 10
    for (int i = 0; i < 32; i++) mem[i] = 4'hF;
    sync();
    clr_exp_addr = 0;
    ifc.clr_req = 1'b1;
    sync();
    ifc.clr_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (ifc.clr_busy && ifc.ram_address == 5'd10) begin found = 1'b1; break; end
    end
    chk("clr_reached_addr10", int'(found), 1);
    #1;
    resetn = 1'b0;
    #1;
    chk("async_rst_wren", int'(ifc.ram_wren), 0);
    chk("async_rst_busy", int'(ifc.clr_busy), 0);
    sync();
    resetn = 1'b1;
    exp_a = 4'h0; exp_b = 4'h0;
    a_read(5'd0, 4'h0);
    a_read(5'd9, 4'h0);
    a_read(5'd10, 4'hF);
    a_read(5'd31, 4'hF);

    // A writes addr 2 (its rdata holds), then B reads the new value
    a_write(5'd2, 4'h6);
    b_read(5'd2, 4'h6);

    repeat (10) @(negedge clock);
    chk("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
